imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Loads a program into the single-cycle processor's instruction memory from a byte stream.
- Holds the processor stopped (cpu_run=0) while loading. Releases it once the last word is written.
- Sits between the bench/host byte source and the instruction-memory write port.
- Produces the CPU run/enable that the processor's clock-driven fetch consumes.

Parameters:
ADDR_W, 8, instruction-memory word-address width; depth = 2**ADDR_W words of 32 bits.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a load; sampled only in IDLE
len  in  ADDR_W+1  number of 32-bit words to load; sampled with an accepted start
byte_valid  in  1  source has a byte
byte_data  in  8  program byte, little-endian within each word
byte_ready  out  1  loader accepts a byte this cycle
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  word address of the write
imem_wdata  out  32  word being written
cpu_run  out  1  processor enable; 0 = processor held
busy  out  1  load in progress (LOAD or WRITE state)
done  out  1  one-cycle pulse when a load completes
err  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0, async): all outputs 0, FSM=IDLE, byte/word counters 0, assembly register 0.
- Reset mid-load aborts the load:
  - A partial word is discarded.
  - Words already written stay in memory.
  - cpu_run stays 0 until a new load completes.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - byte_ready=0; cpu_run keeps its current value.
  - On start=1:
    - len > 2**ADDR_W: err<=1, stay IDLE, cpu_run unchanged.
    - len == 0: err<=0, go DONE (no writes).
    - Otherwise: err<=0, cpu_run<=0, word_cnt<=0, byte_cnt<=0, go LOAD.
- LOAD:
  - byte_ready=1, busy=1.
  - A handshake is byte_valid & byte_ready. On each handshake, byte_data goes to bits [8*byte_cnt+7 : 8*byte_cnt] of the assembly register, and byte_cnt increments mod 4.
  - The handshake with byte_cnt==3 transitions to WRITE.
  - No handshake: stay, no change.
- WRITE (exactly 1 cycle):
  - byte_ready=0, busy=1.
  - imem_we=1, imem_addr=word_cnt[ADDR_W-1:0], imem_wdata=assembled word.
  - If word_cnt == len-1: go DONE; else word_cnt++ and go LOAD.
  - Latency: the write strobe is asserted the cycle after the 4th byte handshake.
  - Max throughput: 4 bytes per 5 cycles.
- DONE (1 cycle):
  - done=1, cpu_run<=1 (visible from this cycle), busy=0, then go IDLE.
- start while busy (LOAD/WRITE): ignored, err<=1, the load continues unaffected.
- err is cleared only by an accepted start or by reset.
- imem_we is 0 in every state except WRITE. imem_addr and imem_wdata hold their last values outside WRITE.
- Address wrap cannot occur: the maximum legal len writes addresses 0..2**ADDR_W-1 exactly.
- byte_data is ignored when byte_ready=0. Bytes offered outside LOAD are not consumed.

Test Plan:
1. Reset, start with len=2, bytes 78 56 34 12 EF BE AD DE sent back-to-back -> imem_we pulses twice:
   - addr 0 = 0x12345678, addr 1 = 0xDEADBEEF.
   - cpu_run 0 during load, done pulse one cycle after the 2nd write, then cpu_run=1.
2. Same load with byte_valid toggled 1/0 every cycle -> identical writes and data, and byte_ready never drops in LOAD.
3. len=0 with ADDR_W=8 -> no imem_we, done pulse the cycle after start, cpu_run=1, err=0.
4. len=257 (ADDR_W=8) -> err=1, no state change, cpu_run keeps its prior value. A subsequent start with len=1 clears err and loads correctly.
5. start asserted during LOAD of a len=3 load -> err=1. The load completes with 3 writes at addr 0..2, done pulses once.
6. rst_n low after 2 bytes of the 2nd word of a len=4 load:
   - All outputs go 0 immediately (async), the partial word is never written.
   - A new len=1 load afterwards writes addr 0 correctly.

Source files
------------

// File: rtl/imem_program_loader.sv
// imem_program_loader: assembles a little-endian byte stream into 32-bit
// words and writes them to instruction memory. The processor is held
// (cpu_run=0) while a load is in progress and is released when it finishes.
module imem_program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state;
  state_t              state_next;
  logic [1:0]          byte_cnt;
  logic [ADDR_W:0]     word_cnt;
  logic [ADDR_W:0]     len_q;
  logic [31:0]         asm_word;
  logic [ADDR_W-1:0]   addr_hold;
  logic [31:0]         wdata_hold;
  logic                run_q;
  logic                err_q;
  logic                len_ok;
  logic                last_word;

  assign len_ok    = (len <= DEPTH);
  assign last_word = (word_cnt == (len_q - ONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && len_ok) state_next = (len == '0) ? DONE : LOAD;
      LOAD:    if (byte_valid && (byte_cnt == 2'd3)) state_next = WRITE;
      WRITE:   state_next = last_word ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; address/data hold their last written value
  always_comb begin
    byte_ready = (state == LOAD);
    imem_we    = (state == WRITE);
    busy       = (state == LOAD) || (state == WRITE);
    done       = (state == DONE);
    imem_addr  = (state == WRITE) ? word_cnt[ADDR_W-1:0] : addr_hold;
    imem_wdata = (state == WRITE) ? asm_word : wdata_hold;
    cpu_run    = run_q || (state == DONE);
    err        = err_q;
  end

  // Byte assembly, word counter and held write address/data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= '0;
      word_cnt   <= '0;
      len_q      <= '0;
      asm_word   <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && len_ok) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            len_q    <= len;
          end
        end
        LOAD: begin
          if (byte_valid) begin
            asm_word[{byte_cnt, 3'b000} +: 8] <= byte_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          addr_hold  <= word_cnt[ADDR_W-1:0];
          wdata_hold <= asm_word;
          if (!last_word) word_cnt <= word_cnt + ONE;
        end
        default: ;
      endcase
    end
  end

  // Processor-run and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!len_ok) begin
              err_q <= 1'b1;
            end else begin
              err_q <= 1'b0;
              if (len != '0) run_q <= 1'b0;
            end
          end
        end
        LOAD, WRITE: if (start) err_q <= 1'b1;
        DONE:        run_q <= 1'b1;
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: drives byte-stream loads and checks every memory
// write, done pulse and status flag against a scoreboard.
module tb_imem_program_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              busy;
  logic              done;
  logic              err;

  imem_program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  bit          exp_done_q[$];
  logic [31:0] words [DEPTH];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        prev_we = 1'b0;

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops expected writes and done pulses whenever the DUT presents them
  always @(negedge clk) begin
    wr_t w;
    if (rst_n) begin
      check_output("byte_ready_rule", {31'b0, byte_ready}, {31'b0, busy && !imem_we});
      if (busy) check_output("cpu_held_in_load", {31'b0, cpu_run}, 32'd0);
      if (imem_we) begin
        if (exp_wr.size() == 0) begin
          check_output("write_expected", exp_wr.size(), 32'd1);
        end else begin
          w = exp_wr.pop_front();
          check_output("write_addr", {24'b0, imem_addr}, w.addr);
          check_output("write_data", imem_wdata, w.data);
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          check_output("done_expected", exp_done_q.size(), 32'd1);
        end else begin
          if (exp_done_q.pop_front()) check_output("done_after_write", {31'b0, prev_we}, 32'd1);
          check_output("done_cpu_run", {31'b0, cpu_run}, 32'd1);
          check_output("done_not_busy", {31'b0, busy}, 32'd0);
        end
      end
      prev_we = imem_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) words[i] = $urandom;
  endtask

  // One load of n words from words[]; mode 0 back-to-back, 1 toggled, 2 random gaps.
  // inject_at >= 0 raises start mid-load; abort_after >= 0 resets after that many bytes.
  task automatic apply_stimulus(input int n, input int mode, input int inject_at, input int abort_after);
    int idx, cycles, total, budget;
    bit toggle, v, injected, seen;
    total  = n * 4;
    budget = total * 8 + 20;
    @(negedge clk);
    start = 1'b1;
    len   = n[ADDR_W:0];
    if (abort_after < 0) exp_done_q.push_back(n != 0);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      check_output("zero_len_done", {31'b0, done}, 32'd1);
      check_output("zero_len_cpu_run", {31'b0, cpu_run}, 32'd1);
      check_output("zero_len_err", {31'b0, err}, 32'd0);
      return;
    end
    idx = 0; cycles = 0; toggle = 1'b1; injected = 1'b0;
    while (idx < total && cycles < budget) begin
      if (abort_after >= 0 && idx == abort_after) break;
      case (mode)
        0:       v = 1'b1;
        1:       begin v = toggle; toggle = ~toggle; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (!injected && inject_at == idx) begin
        start = 1'b1;
        len = 9'd5;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      byte_valid = v;
      byte_data  = v ? words[idx/4][8*(idx%4) +: 8] : 8'($urandom);
      if (v && byte_ready) begin
        if (idx % 4 == 3) exp_wr.push_back('{idx / 4, words[idx/4]});
        idx++;
      end
      @(negedge clk);
      cycles++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    check_output("bytes_consumed", idx, (abort_after >= 0) ? abort_after : total);
    if (abort_after >= 0) begin
      #2 rst_n = 1'b0;
      #1;
      check_output("abort_imem_we", {31'b0, imem_we}, 32'd0);
      check_output("abort_busy", {31'b0, busy}, 32'd0);
      check_output("abort_byte_ready", {31'b0, byte_ready}, 32'd0);
      check_output("abort_cpu_run", {31'b0, cpu_run}, 32'd0);
      check_output("abort_addr", {24'b0, imem_addr}, 32'd0);
      check_output("abort_wdata", imem_wdata, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_output("abort_cpu_stays_held", {31'b0, cpu_run}, 32'd0);
      check_output("abort_pending_writes", exp_wr.size(), 32'd0);
      return;
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_output("done_seen", {31'b0, seen}, 32'd1);
    check_output("load_cpu_run", {31'b0, cpu_run}, 32'd1);
    check_output("load_err", {31'b0, err}, {31'b0, inject_at >= 0});
    check_output("load_pending_writes", exp_wr.size(), 32'd0);
  endtask

  // Stimulus sequence
  initial begin
    repeat (2) @(negedge clk);
    check_output("reset_cpu_run", {31'b0, cpu_run}, 32'd0);
    check_output("reset_busy", {31'b0, busy}, 32'd0);
    check_output("reset_done", {31'b0, done}, 32'd0);
    check_output("reset_err", {31'b0, err}, 32'd0);
    check_output("reset_imem_we", {31'b0, imem_we}, 32'd0);
    check_output("reset_byte_ready", {31'b0, byte_ready}, 32'd0);
    check_output("reset_addr", {24'b0, imem_addr}, 32'd0);
    check_output("reset_wdata", imem_wdata, 32'd0);
    #2 rst_n = 1'b1;

    $display("[TB] fixed two-word load, back-to-back bytes");
    words[0] = 32'h1234_5678;
    words[1] = 32'hDEAD_BEEF;
    apply_stimulus(2, 0, -1, -1);

    $display("[TB] same load with byte_valid toggling");
    apply_stimulus(2, 1, -1, -1);

    $display("[TB] zero-length load");
    apply_stimulus(0, 0, -1, -1);

    $display("[TB] oversize length rejected");
    @(negedge clk);
    start = 1'b1;
    len = 9'd257;
    @(negedge clk);
    start = 1'b0;
    check_output("oversize_err", {31'b0, err}, 32'd1);
    check_output("oversize_busy", {31'b0, busy}, 32'd0);
    check_output("oversize_done", {31'b0, done}, 32'd0);
    check_output("oversize_cpu_run", {31'b0, cpu_run}, 32'd1);
    @(negedge clk);
    check_output("oversize_still_idle", {31'b0, busy}, 32'd0);
    fill_random(1);
    apply_stimulus(1, 0, -1, -1);

    $display("[TB] start during load");
    fill_random(3);
    apply_stimulus(3, 0, 5, -1);

    $display("[TB] random loads");
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 6);
      fill_random(n);
      apply_stimulus(n, 2, -1, -1);
    end

    $display("[TB] full-depth load");
    fill_random(DEPTH);
    apply_stimulus(DEPTH, 0, -1, -1);

    $display("[TB] reset mid-load");
    fill_random(4);
    apply_stimulus(4, 0, -1, 6);
    fill_random(1);
    apply_stimulus(1, 0, -1, -1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
